// File: rtl/colour_target_scheduler.sv
// rtl/colour_target_scheduler.sv - per-frame target colour scheduling and bounding-box result reporting
module colour_target_scheduler #(
    parameter int X_W        = 10,
    parameter int Y_W        = 9,
    parameter int COUNT_W    = 19,
    parameter int MIN_PIXELS = 64,
    parameter int MISS_LIMIT = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [4:0]         i_colour_en,
    input  logic               i_sof,
    input  logic               i_eof,
    input  logic               i_pix_valid,
    input  logic [X_W-1:0]     i_pix_x,
    input  logic [Y_W-1:0]     i_pix_y,
    input  logic [4:0]         i_hit_flags,
    output logic [4:0]         o_colour_sel,
    output logic               o_res_valid,
    input  logic               i_res_ready,
    output logic [2:0]         o_res_colour,
    output logic               o_res_found,
    output logic [X_W-1:0]     o_res_cx,
    output logic [Y_W-1:0]     o_res_cy,
    output logic [COUNT_W-1:0] o_res_count
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_ACCUM,
        S_EVAL,
        S_REPORT
    } state_t;

    localparam logic [3:0]         LP_MISS_LIMIT = 4'(MISS_LIMIT);
    localparam logic [COUNT_W-1:0] LP_MIN        = COUNT_W'(MIN_PIXELS);
    localparam logic [COUNT_W-1:0] LP_SAT        = '1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_cur;
    logic [3:0]         r_miss;
    logic               r_lock;
    logic [4:0]         r_sel;
    logic [COUNT_W-1:0] r_count;
    logic [X_W-1:0]     r_xmin;
    logic [X_W-1:0]     r_xmax;
    logic [Y_W-1:0]     r_ymin;
    logic [Y_W-1:0]     r_ymax;
    logic               r_res_valid;
    logic [2:0]         r_res_colour;
    logic               r_res_found;
    logic [X_W-1:0]     r_res_cx;
    logic [Y_W-1:0]     r_res_cy;
    logic [COUNT_W-1:0] r_res_count;

    logic               w_sof;
    logic               w_eof;
    logic               w_en_any;
    logic               w_hit;
    logic               w_handshake;
    logic               w_start;
    logic               w_accum;
    logic [COUNT_W-1:0] w_cnt_b;
    logic [COUNT_W-1:0] w_cnt_n;
    logic [X_W-1:0]     w_xmin_b;
    logic [X_W-1:0]     w_xmin_n;
    logic [X_W-1:0]     w_xmax_b;
    logic [X_W-1:0]     w_xmax_n;
    logic [Y_W-1:0]     w_ymin_b;
    logic [Y_W-1:0]     w_ymin_n;
    logic [Y_W-1:0]     w_ymax_b;
    logic [Y_W-1:0]     w_ymax_n;
    logic               w_found;
    logic [X_W:0]       w_sum_x;
    logic [Y_W:0]       w_sum_y;
    logic [2:0]         w_idle_idx;
    logic [2:0]         w_adv_idx;
    logic               w_adv;
    logic [2:0]         w_cur_n;
    logic               w_lock_n;
    logic [3:0]         w_miss_n;

    // First enabled index found walking upward from start and wrapping; start if none enabled.
    function automatic logic [2:0] f_pick(input logic [4:0] en, input logic [2:0] start);
        logic [2:0] v_idx;
        logic [2:0] v_res;
        logic       v_done;
        v_idx  = start;
        v_res  = start;
        v_done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (!v_done && en[v_idx]) begin
                v_res  = v_idx;
                v_done = 1'b1;
            end
            v_idx = (v_idx == 3'd4) ? 3'd0 : v_idx + 3'd1;
        end
        return v_res;
    endfunction

    assign w_sof       = i_sof & i_pix_valid;
    assign w_eof       = i_eof & i_pix_valid;
    assign w_en_any    = |i_colour_en;
    assign w_hit       = i_pix_valid & (|(i_hit_flags & r_sel));
    assign w_handshake = (r_state == S_REPORT) & r_res_valid & i_res_ready;
    assign w_idle_idx  = f_pick(i_colour_en, r_cur);
    assign w_adv_idx   = f_pick(i_colour_en, (r_cur == 3'd4) ? 3'd0 : r_cur + 3'd1);
    assign w_found     = (r_count >= LP_MIN);
    assign w_sum_x     = {1'b0, r_xmin} + {1'b0, r_xmax};
    assign w_sum_y     = {1'b0, r_ymin} + {1'b0, r_ymax};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_accum     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_en_any) begin
                    w_state_nxt = S_WAIT_SOF;
                end
            end
            S_WAIT_SOF: begin
                if (!w_en_any) begin
                    w_state_nxt = S_IDLE;
                end else if (w_sof) begin
                    w_start     = 1'b1;
                    w_accum     = 1'b1;
                    w_state_nxt = w_eof ? S_EVAL : S_ACCUM;
                end
            end
            S_ACCUM: begin
                // A sof seen here means the previous eof was lost: restart from this pixel.
                if (i_pix_valid) begin
                    w_accum = 1'b1;
                    w_start = w_sof;
                    if (w_eof) begin
                        w_state_nxt = S_EVAL;
                    end
                end
            end
            S_EVAL: begin
                w_state_nxt = S_REPORT;
            end
            S_REPORT: begin
                if (w_handshake) begin
                    w_state_nxt = w_en_any ? S_WAIT_SOF : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_cnt_b  = w_start ? '0 : r_count;
        w_xmin_b = w_start ? '1 : r_xmin;
        w_xmax_b = w_start ? '0 : r_xmax;
        w_ymin_b = w_start ? '1 : r_ymin;
        w_ymax_b = w_start ? '0 : r_ymax;
        w_cnt_n  = w_cnt_b;
        w_xmin_n = w_xmin_b;
        w_xmax_n = w_xmax_b;
        w_ymin_n = w_ymin_b;
        w_ymax_n = w_ymax_b;
        if (w_hit) begin
            if (w_cnt_b != LP_SAT) begin
                w_cnt_n = w_cnt_b + COUNT_W'(1);
            end
            if (i_pix_x < w_xmin_b) w_xmin_n = i_pix_x;
            if (i_pix_x > w_xmax_b) w_xmax_n = i_pix_x;
            if (i_pix_y < w_ymin_b) w_ymin_n = i_pix_y;
            if (i_pix_y > w_ymax_b) w_ymax_n = i_pix_y;
        end
    end

    // Schedule decision applied when the reported result is accepted.
    always_comb begin
        w_cur_n  = r_cur;
        w_lock_n = r_lock;
        w_miss_n = r_miss;
        w_adv    = 1'b0;
        if (!i_colour_en[r_cur]) begin
            w_adv = 1'b1;
        end else if (r_res_found) begin
            w_lock_n = 1'b1;
            w_miss_n = 4'd0;
        end else if (r_lock) begin
            if (r_miss + 4'd1 >= LP_MISS_LIMIT) begin
                w_adv = 1'b1;
            end else begin
                w_miss_n = r_miss + 4'd1;
            end
        end else begin
            w_adv = 1'b1;
        end
        if (w_adv) begin
            w_lock_n = 1'b0;
            w_miss_n = 4'd0;
            if (w_en_any) begin
                w_cur_n = w_adv_idx;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cur        <= 3'd0;
            r_miss       <= 4'd0;
            r_lock       <= 1'b0;
            r_sel        <= 5'd0;
            r_count      <= '0;
            r_xmin       <= '0;
            r_xmax       <= '0;
            r_ymin       <= '0;
            r_ymax       <= '0;
            r_res_valid  <= 1'b0;
            r_res_colour <= 3'd0;
            r_res_found  <= 1'b0;
            r_res_cx     <= '0;
            r_res_cy     <= '0;
            r_res_count  <= '0;
        end else begin
            if (w_accum) begin
                r_count <= w_cnt_n;
                r_xmin  <= w_xmin_n;
                r_xmax  <= w_xmax_n;
                r_ymin  <= w_ymin_n;
                r_ymax  <= w_ymax_n;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_en_any) begin
                        r_cur <= w_idle_idx;
                        r_sel <= 5'd1 << w_idle_idx;
                    end
                end
                S_WAIT_SOF: begin
                    if (!w_en_any) begin
                        r_sel <= 5'd0;
                    end
                end
                S_EVAL: begin
                    r_res_valid  <= 1'b1;
                    r_res_colour <= r_cur;
                    r_res_found  <= w_found;
                    r_res_cx     <= w_found ? w_sum_x[X_W:1] : '0;
                    r_res_cy     <= w_found ? w_sum_y[Y_W:1] : '0;
                    r_res_count  <= r_count;
                end
                S_REPORT: begin
                    if (w_handshake) begin
                        r_res_valid <= 1'b0;
                        r_cur       <= w_cur_n;
                        r_lock      <= w_lock_n;
                        r_miss      <= w_miss_n;
                        r_sel       <= w_en_any ? (5'd1 << w_cur_n) : 5'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_colour_sel = r_sel;
    assign o_res_valid  = r_res_valid;
    assign o_res_colour = r_res_colour;
    assign o_res_found  = r_res_found;
    assign o_res_cx     = r_res_cx;
    assign o_res_cy     = r_res_cy;
    assign o_res_count  = r_res_count;
endmodule
